// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64 M-extension multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide retire one bit per cycle.
// Divide-by-zero, signed overflow and undefined op codes finish in one cycle.
module muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic        flush,
   output logic        ready,
   output logic        done,
   output logic [63:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   state_t state, state_next;

   // Latched operation. a_q is the multiplicand or the shifting dividend,
   // b_q the multiplier or the divisor, acc_q the product or partial remainder.
   logic [3:0]  op_q;
   logic [63:0] a_q, b_q, acc_q, quo_q, result_q;
   logic [5:0]  cnt_q;
   logic        neg_quo_q, neg_rem_q, done_q;

   logic        accept;

   // Request decode: operand extension, magnitudes and fast-path results
   logic [2:0]  in_fn;
   logic        in_w, in_undef, in_div, in_signed, in_rem;
   logic        sgn1, sgn2, in_div0, in_ovf, in_fast;
   logic [63:0] sx1, ext1, ext2, mag1, mag2, fast_res;

   always_comb begin
      in_fn     = op[2:0];
      in_w      = op[3];
      in_undef  = (in_fn > 3'd4);
      in_div    = (in_fn != 3'd0) && !in_undef;
      in_signed = (in_fn == 3'd1) || (in_fn == 3'd3);
      in_rem    = (in_fn == 3'd3) || (in_fn == 3'd4);
      sx1       = in_w ? {{32{src1[31]}}, src1[31:0]} : src1;
      ext1      = (in_w && !in_signed) ? {32'b0, src1[31:0]} : sx1;
      if (!in_w)
         ext2 = src2;
      else if (in_signed)
         ext2 = {{32{src2[31]}}, src2[31:0]};
      else
         ext2 = {32'b0, src2[31:0]};
      sgn1    = in_signed && ext1[63];
      sgn2    = in_signed && ext2[63];
      mag1    = sgn1 ? -ext1 : ext1;
      mag2    = sgn2 ? -ext2 : ext2;
      in_div0 = (ext2 == '0);
      if (in_w)
         in_ovf = in_signed && (src1[31:0] == 32'h8000_0000) && (src2[31:0] == '1);
      else
         in_ovf = in_signed && (src1 == {1'b1, 63'b0}) && (src2 == '1);
      in_fast  = in_undef || (in_div && (in_div0 || in_ovf));
      fast_res = '0;
      if (in_div && in_div0)
         fast_res = in_rem ? sx1 : '1;
      else if (in_div && in_ovf)
         fast_res = in_rem ? '0 : sx1;
   end

   // One iteration step plus the sign fix-up applied on the final step
   logic        l_w, l_div, l_rem, ge;
   logic [64:0] trial;
   logic [63:0] diff, acc_step, quo_step, raw, fin;

   always_comb begin
      l_w   = op_q[3];
      l_div = (op_q[2:0] != 3'd0);
      l_rem = (op_q[2:0] == 3'd3) || (op_q[2:0] == 3'd4);
      trial = {acc_q, a_q[63]};
      ge    = (trial >= {1'b0, b_q});
      // When ge holds the true difference is below 2^64, so 64 bits suffice.
      diff  = trial[63:0] - b_q;
      if (l_div) begin
         acc_step = ge ? diff : trial[63:0];
         quo_step = {quo_q[62:0], ge};
      end else begin
         acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
         quo_step = quo_q;
      end
      if (!l_div)
         raw = acc_step;
      else if (l_rem)
         raw = neg_rem_q ? -acc_step : acc_step;
      else
         raw = neg_quo_q ? -quo_step : quo_step;
      fin = l_w ? {{32{raw[31]}}, raw[31:0]} : raw;
   end

   assign accept = (state == S_IDLE) && start && !flush;
   assign ready  = (state == S_IDLE);
   assign done   = done_q;
   assign result = result_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = in_fast ? S_DONE : S_BUSY;
         S_BUSY:  if (cnt_q == '0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (flush)
         state_next = S_IDLE;
   end

   // Operand capture, iteration datapath, result and done registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state_next == S_DONE);
         if (accept) begin
            op_q      <= op;
            cnt_q     <= in_w ? 6'd31 : 6'd63;
            acc_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= sgn1 ^ sgn2;
            neg_rem_q <= sgn1;
            if (in_div) begin
               // W dividends sit in the top half so the MSB-first shift sees them.
               a_q <= in_w ? {mag1[31:0], 32'b0} : mag1;
               b_q <= mag2;
            end else begin
               a_q <= src1;
               b_q <= src2;
            end
            if (in_fast)
               result_q <= fast_res;
         end else if (state == S_BUSY && !flush) begin
            acc_q <= acc_step;
            quo_q <= quo_step;
            a_q   <= a_q << 1;
            if (!l_div)
               b_q <= b_q >> 1;
            if (cnt_q == '0)
               result_q <= fin;
            else
               cnt_q <= cnt_q - 6'd1;
         end
      end
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multi-cycle multiply/divide sequencer for the RV64 execute stage. It accepts one M-extension operation at a time through a start/ready handshake and runs a radix-2 shift-add multiply or restoring divide over 64 (or 32 for W ops) cycles. It resolves the divide special cases in one cycle and pulses `done` with the 64-bit result. The execute stage stalls while `ready` is low and routes `result` to the writeback mux in place of the single-cycle ALU output.

## Interface
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request; accepted only when `ready`=1.
- `op`  in  4  — operation code:
  - 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU.
  - 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW.
  - Bit 3 selects the W (32-bit) variant.
- `src1`, `src2`  in  64 (`word_t`)  — operands.
- `flush`  in  1  — abort the current operation and drop any request.
- `ready`  out  1  — high only in IDLE.
- `done`  out  1  — one-cycle pulse; `result` is valid in that cycle.
- `result`  out  64 (`word_t`)  — registered result; holds its value until the next `done`.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE→BUSY: `start` && !`flush` for a normal op.
  - IDLE→DONE: `start` && !`flush` for a fast-path op.
  - BUSY→DONE: after N BUSY cycles. N=64 for full-width ops, N=32 for W ops.
  - DONE→IDLE: always, after one cycle.
  - Any state→IDLE: when `flush`=1.
- **Operand capture:** `op`, `src1` and `src2` are latched at acceptance. Later changes on the inputs are ignored.
- **W ops:** only operand bits [31:0] are used. For DIVW/REMW they are sign-extended before magnitude conversion; for DIVUW/REMUW they are zero-extended. The 32-bit result is sign-extended from bit 31 into [63:32] for all W ops, including unsigned ones.
- **Multiply:**
  - Unsigned shift-add on the latched operands, one multiplier bit per cycle.
  - Only the low 64 bits (low 32 for MULW) are kept. Signedness is irrelevant to these low bits.
- **Divide:**
  - Signed ops convert both operands to magnitudes, then run a restoring divide producing one quotient bit per cycle.
  - Signs are fixed in the DONE transition: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- **Fast path (latency 1, BUSY skipped):**
  - Divisor = 0: quotient = all ones, remainder = dividend. For W ops the dividend is the sign-extended [31:0].
  - Signed overflow (dividend = most negative value, divisor = −1, at 64 or 32 bits per op): quotient = dividend, remainder = 0.
  - Undefined `op` codes (5–7, 13–15): result = 0.
- **Counter:** 6-bit iteration counter, loaded at acceptance, decremented each BUSY cycle. It cannot wrap because BUSY exits when it reaches the last iteration.

## Timing
- **Reset:** state = IDLE, `ready`=1, `done`=0, `result`=0, counter and operand registers = 0.
- **Normal latency:**
  - Accept at edge E0; BUSY for N cycles; `done`=1 in the cycle after edge E0+N.
  - That is 65 cycles after the accept cycle for full-width ops, 33 for W ops.
- **Fast-path latency:** `done`=1 in the cycle immediately after the accept cycle.
- **Back-to-back:** the earliest next accept is the cycle after DONE, when `ready`=1 again. `start` during DONE is ignored.
- **Flush:**
  - Takes effect at the next edge and wins over a simultaneous `start`.
  - Flush during DONE: `done` still reads 1 in that cycle, but the consumer must discard it. The FSM returns to IDLE; `result` is unchanged by the flush.
  - Flush during BUSY: `done` is never raised for the aborted op.
- **Reset mid-operation:** immediate return to the reset values; no `done`.
- **Ready/done encoding:** `ready` is a combinational decode of the state; `done` is a registered decode of state==DONE.

## Test plan
- MUL 3 × 5 → `ready` low for 65 cycles; `done` one cycle with `result`=15; `ready` high the following cycle.
- MULW 0x40000000 × 2 → `result`=0xFFFFFFFF80000000, `done` 33 cycles after accept.
- DIVW −7 / 2 (`src1`=0xFFFFFFF9), then REMW with the same operands → `result`=0xFFFFFFFFFFFFFFFD, then 0xFFFFFFFFFFFFFFFF.
- Divide special cases:
  - DIVU 10 / 0 → `result`=0xFFFFFFFFFFFFFFFF, `done` the cycle after accept.
  - REM 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → `result`=0, latency 1.
- DIV 100 / 7 with `flush` asserted at BUSY cycle 20 → no `done`, `ready`=1 next cycle. Then REMU 100 / 7 → `result`=2 at latency 65.
- `reset` pulsed mid-BUSY and `start`+`flush` in the same cycle → all outputs return to reset values; no acceptance, `ready` stays 1.
